// File: rtl/channel_scan_ctrl.sv
// channel_scan_ctrl
//   Sequencer for a downstream 4-to-1 2-bit data selector. It walks the
//   enabled channels in ascending order and holds each one for DWELL cycles
//   with the selector enabled. Every channel change gets one blanking cycle
//   with the selector disabled, so the output Y never shows a mix of two
//   channels. A SAMPLE strobe marks the last enabled cycle of each visit,
//   which tells the consumer when to latch Y.
//
// Parameters
//   DWELL  cycles EN is held low per channel visit (1 .. 2**CNT_W-1)
//   CNT_W  width of the dwell counter
//
// Ports
//   CLK     in   1  clock, rising edge
//   RST     in   1  synchronous active-high reset
//   START   in   1  begin a sweep (only looked at while idle)
//   STOP    in   1  abort the sweep (only looked at while busy)
//   MODE    in   1  0 = single sweep, 1 = continuous sweeps
//   MASK    in   4  channel enables, bit n = channel n
//   S       out  2  selector channel
//   EN      out  1  selector enable, active low
//   SAMPLE  out  1  pulse in the last dwell cycle of each visit
//   BUSY    out  1  high whenever not idle
//   DONE    out  1  pulse when a single sweep completes normally
module channel_scan_ctrl #(
   parameter int DWELL = 4,
   parameter int CNT_W = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       STOP,
   input  logic       MODE,
   input  logic [3:0] MASK,
   output logic [1:0] S,
   output logic       EN,
   output logic       SAMPLE,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BLANK,
      ST_DWELL
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [3:0]       mask_q;
   logic [3:0]       mask_n;
   logic             mode_q;
   logic             mode_n;
   logic [1:0]       s_n;
   logic             en_n;
   logic             sample_n;
   logic             busy_n;
   logic             done_n;
   logic [2:0]       above;

   // Lowest set bit of a mask; callers only use it with a non-zero mask.
   function automatic logic [1:0] lowest_set(input logic [3:0] m);
      lowest_set = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) lowest_set = 2'(i);
      end
   endfunction

   // Next set bit strictly above the current channel; MSB flags that one exists.
   function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
      next_above = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) next_above = {1'b1, 2'(i)};
      end
   endfunction

   assign above = next_above(mask_q, S);

   // State, counter, captured configuration and every output are registered
   // together, so the selector sees S and EN change on the same edge and the
   // blanking cycle is exactly the cycle in which S moves.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         mask_q <= 4'b0000;
         mode_q <= 1'b0;
         S      <= 2'd0;
         EN     <= 1'b1;
         SAMPLE <= 1'b0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         mask_q <= mask_n;
         mode_q <= mode_n;
         S      <= s_n;
         EN     <= en_n;
         SAMPLE <= sample_n;
         BUSY   <= busy_n;
         DONE   <= done_n;
      end
   end

   // Next-state and next-output logic. The outputs computed here describe
   // the cycle being entered: EN goes low only when entering a dwell cycle,
   // and SAMPLE is raised when the counter being entered is the final one.
   // STOP is tested before the end-of-visit decision so an abort never
   // produces DONE or a channel advance.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      mask_n   = mask_q;
      mode_n   = mode_q;
      s_n      = S;
      en_n     = 1'b1;
      sample_n = 1'b0;
      done_n   = 1'b0;

      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (START && (MASK != 4'b0000)) begin
               mask_n  = MASK;
               mode_n  = MODE;
               s_n     = lowest_set(MASK);
               state_n = ST_BLANK;
            end
         end

         ST_BLANK: begin
            cnt_n = '0;
            if (STOP) begin
               state_n = ST_IDLE;
            end else begin
               state_n  = ST_DWELL;
               en_n     = 1'b0;
               sample_n = (LAST == '0);
            end
         end

         ST_DWELL: begin
            if (STOP) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else if (cnt == LAST) begin
               cnt_n = '0;
               if (above[2]) begin
                  s_n     = above[1:0];
                  state_n = ST_BLANK;
               end else if (mode_q) begin
                  s_n     = lowest_set(mask_q);
                  state_n = ST_BLANK;
               end else begin
                  state_n = ST_IDLE;
                  done_n  = 1'b1;
               end
            end else begin
               cnt_n    = cnt + 1'b1;
               en_n     = 1'b0;
               sample_n = (cnt_n == LAST);
            end
         end

         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase

      busy_n = (state_n != ST_IDLE);
   end

endmodule

// File: tb/tb_channel_scan_ctrl.sv
// tb_channel_scan_ctrl
//   Bench for channel_scan_ctrl. Two instances share the same inputs: one
//   with DWELL=4 and one with DWELL=1. A sweep model describes each instance
//   as a running cycle count since START. The visit index is that count
//   divided by (DWELL+1), and the position within the visit is the remainder.
//   Every output follows from those two numbers. Directed checks with
//   hand-worked values sit in the stimulus thread.
module tb_channel_scan_ctrl;

   logic       CLK;
   logic       RST;
   logic       START;
   logic       STOP;
   logic       MODE;
   logic [3:0] MASK;

   logic [1:0] s_w      [2];
   logic       en_w     [2];
   logic       sample_w [2];
   logic       busy_w   [2];
   logic       done_w   [2];

   int tests_run    = 0;
   int tests_failed = 0;
   bit check_en     = 1'b0;

   // Sweep model state per instance.
   bit         m_active [2] = '{1'b0, 1'b0};
   int         m_p      [2] = '{0, 0};
   logic [3:0] m_mask   [2] = '{4'd0, 4'd0};
   bit         m_mode   [2] = '{1'b0, 1'b0};
   logic [1:0] m_slast  [2] = '{2'd0, 2'd0};
   bit         m_done   [2] = '{1'b0, 1'b0};

   channel_scan_ctrl #(.DWELL(4), .CNT_W(4)) dut4 (
      .CLK    (CLK),
      .RST    (RST),
      .START  (START),
      .STOP   (STOP),
      .MODE   (MODE),
      .MASK   (MASK),
      .S      (s_w[0]),
      .EN     (en_w[0]),
      .SAMPLE (sample_w[0]),
      .BUSY   (busy_w[0]),
      .DONE   (done_w[0])
   );

   channel_scan_ctrl #(.DWELL(1), .CNT_W(4)) dut1 (
      .CLK    (CLK),
      .RST    (RST),
      .START  (START),
      .STOP   (STOP),
      .MODE   (MODE),
      .MASK   (MASK),
      .S      (s_w[1]),
      .EN     (en_w[1]),
      .SAMPLE (sample_w[1]),
      .BUSY   (busy_w[1]),
      .DONE   (done_w[1])
   );

   // Free-running clock, period 10.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic int dw(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic int popc(input logic [3:0] m);
      int c = 0;
      for (int b = 0; b < 4; b++) if (m[b]) c++;
      return c;
   endfunction

   // n-th enabled channel counting upward from channel 0.
   function automatic logic [1:0] nth_chan(input logic [3:0] m, input int n);
      int seen = 0;
      logic [1:0] r = 2'd0;
      for (int b = 0; b < 4; b++) begin
         if (m[b]) begin
            if (seen == n) r = 2'(b);
            seen++;
         end
      end
      return r;
   endfunction

   function automatic int model_off(input int i);
      return m_p[i] % (dw(i) + 1);
   endfunction

   function automatic int model_visit(input int i);
      return m_p[i] / (dw(i) + 1);
   endfunction

   function automatic logic [1:0] model_sel(input int i);
      return nth_chan(m_mask[i], model_visit(i) % popc(m_mask[i]));
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge CLK);
      #1;
   endtask

   // Advance the sweep model on each rising edge from the same inputs the
   // DUTs see. A running sweep only counts cycles; it ends on STOP, or at
   // the last position of the last visit when in single-sweep mode.
   always @(posedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         if (RST) begin
            m_active[i] <= 1'b0;
            m_p[i]      <= 0;
            m_mask[i]   <= 4'd0;
            m_mode[i]   <= 1'b0;
            m_slast[i]  <= 2'd0;
            m_done[i]   <= 1'b0;
         end else if (!m_active[i]) begin
            m_done[i] <= 1'b0;
            if (START && (MASK != 4'd0)) begin
               m_active[i] <= 1'b1;
               m_p[i]      <= 0;
               m_mask[i]   <= MASK;
               m_mode[i]   <= MODE;
            end
         end else if (STOP) begin
            m_active[i] <= 1'b0;
            m_slast[i]  <= model_sel(i);
         end else if (!m_mode[i] && (model_off(i) == dw(i)) &&
                      (model_visit(i) == popc(m_mask[i]) - 1)) begin
            m_active[i] <= 1'b0;
            m_done[i]   <= 1'b1;
            m_slast[i]  <= model_sel(i);
         end else begin
            m_p[i] <= m_p[i] + 1;
         end
      end
   end

   // Compare every output of both instances against the model on each
   // falling edge, once reset has been applied.
   always @(negedge CLK) begin
      if (check_en) begin
         for (int i = 0; i < 2; i++) begin
            if (m_active[i]) begin
               checkOutput($sformatf("model d%0d S", i), s_w[i], model_sel(i));
               checkOutput($sformatf("model d%0d EN", i), en_w[i], (model_off(i) == 0) ? 1 : 0);
               checkOutput($sformatf("model d%0d SAMPLE", i), sample_w[i], (model_off(i) == dw(i)) ? 1 : 0);
               checkOutput($sformatf("model d%0d BUSY", i), busy_w[i], 1);
               checkOutput($sformatf("model d%0d DONE", i), done_w[i], 0);
            end else begin
               checkOutput($sformatf("model d%0d S", i), s_w[i], m_slast[i]);
               checkOutput($sformatf("model d%0d EN", i), en_w[i], 1);
               checkOutput($sformatf("model d%0d SAMPLE", i), sample_w[i], 0);
               checkOutput($sformatf("model d%0d BUSY", i), busy_w[i], 0);
               checkOutput($sformatf("model d%0d DONE", i), done_w[i], m_done[i] ? 1 : 0);
            end
         end
      end
   end

   // Directed scenarios with hand-worked expectations. Checks are taken
   // 1 time unit after the edge that produced the values. "E" below is the
   // edge that samples START.
   initial begin
      RST   = 1'b1;
      START = 1'b0;
      STOP  = 1'b0;
      MODE  = 1'b0;
      MASK  = 4'd0;

      // Reset held for two cycles.
      applyStimulus(1);
      check_en = 1'b1;
      applyStimulus(1);
      checkOutput("reset S", s_w[0], 0);
      checkOutput("reset EN", en_w[0], 1);
      checkOutput("reset SAMPLE", sample_w[0], 0);
      checkOutput("reset BUSY", busy_w[0], 0);
      checkOutput("reset DONE", done_w[0], 0);
      RST = 1'b0;
      applyStimulus(1);

      // Single sweep over all four channels, DWELL=4.
      MASK = 4'b1111; MODE = 1'b0; START = 1'b1;
      applyStimulus(1);                         // E
      START = 1'b0;
      checkOutput("sweep S first", s_w[0], 0);
      checkOutput("sweep EN blank", en_w[0], 1);
      checkOutput("sweep BUSY", busy_w[0], 1);
      applyStimulus(1);                         // E+1
      checkOutput("sweep EN dwell", en_w[0], 0);
      applyStimulus(3);                         // E+4
      checkOutput("sweep SAMPLE", sample_w[0], 1);
      applyStimulus(1);                         // E+5
      checkOutput("sweep S second", s_w[0], 1);
      checkOutput("sweep EN change", en_w[0], 1);
      checkOutput("sweep SAMPLE off", sample_w[0], 0);
      applyStimulus(15);                        // E+20
      checkOutput("sweep DONE", done_w[0], 1);
      checkOutput("sweep BUSY end", busy_w[0], 0);
      checkOutput("sweep S hold", s_w[0], 3);
      applyStimulus(1);
      checkOutput("sweep DONE pulse", done_w[0], 0);

      // Continuous sweep over channels 1 and 3, with an ignored START and a
      // STOP in the second dwell cycle of channel 3.
      MASK = 4'b1010; MODE = 1'b1; START = 1'b1;
      applyStimulus(1);                         // E
      START = 1'b0;
      checkOutput("cont S first", s_w[0], 1);
      applyStimulus(5);                         // E+5
      checkOutput("cont S second", s_w[0], 3);
      checkOutput("cont EN change", en_w[0], 1);
      applyStimulus(2);                         // E+7
      MASK = 4'b0001; MODE = 1'b0; START = 1'b1;
      applyStimulus(1);                         // E+8
      START = 1'b0;
      applyStimulus(2);                         // E+10
      checkOutput("cont S wrap", s_w[0], 1);
      checkOutput("cont EN wrap", en_w[0], 1);
      checkOutput("cont BUSY", busy_w[0], 1);
      applyStimulus(7);                         // E+17
      checkOutput("cont S ch3", s_w[0], 3);
      checkOutput("cont EN ch3", en_w[0], 0);
      STOP = 1'b1;
      applyStimulus(1);                         // E+18
      STOP = 1'b0;
      checkOutput("stop BUSY", busy_w[0], 0);
      checkOutput("stop EN", en_w[0], 1);
      checkOutput("stop SAMPLE", sample_w[0], 0);
      checkOutput("stop DONE", done_w[0], 0);
      checkOutput("stop S hold", s_w[0], 3);
      applyStimulus(2);

      // START with an empty mask is ignored.
      MASK = 4'b0000; MODE = 1'b0; START = 1'b1;
      applyStimulus(1);
      START = 1'b0;
      checkOutput("empty BUSY", busy_w[0], 0);
      checkOutput("empty EN", en_w[0], 1);
      checkOutput("empty DONE", done_w[0], 0);
      applyStimulus(2);
      checkOutput("empty BUSY later", busy_w[0], 0);

      // Single channel, continuous, DWELL=1: EN toggles and SAMPLE rides
      // every enabled cycle.
      MASK = 4'b0001; MODE = 1'b1; START = 1'b1;
      applyStimulus(1);                         // E
      START = 1'b0;
      checkOutput("d1 S", s_w[1], 0);
      checkOutput("d1 EN blank", en_w[1], 1);
      applyStimulus(1);                         // E+1
      checkOutput("d1 EN dwell", en_w[1], 0);
      checkOutput("d1 SAMPLE", sample_w[1], 1);
      applyStimulus(1);                         // E+2
      checkOutput("d1 EN blank again", en_w[1], 1);
      checkOutput("d1 SAMPLE off", sample_w[1], 0);
      checkOutput("d1 S constant", s_w[1], 0);
      applyStimulus(6);
      STOP = 1'b1;
      applyStimulus(1);
      STOP = 1'b0;
      checkOutput("d1 stop BUSY", busy_w[1], 0);
      applyStimulus(2);

      // Reset in the middle of channel 2's dwell, then a fresh single
      // channel sweep that must see a cleared counter.
      MASK = 4'b0110; MODE = 1'b0; START = 1'b1;
      applyStimulus(1);                         // E
      START = 1'b0;
      checkOutput("rst S first", s_w[0], 1);
      applyStimulus(7);                         // E+7
      checkOutput("rst S ch2", s_w[0], 2);
      checkOutput("rst EN ch2", en_w[0], 0);
      RST = 1'b1;
      applyStimulus(1);
      RST = 1'b0;
      checkOutput("midrst S", s_w[0], 0);
      checkOutput("midrst EN", en_w[0], 1);
      checkOutput("midrst BUSY", busy_w[0], 0);
      checkOutput("midrst SAMPLE", sample_w[0], 0);
      applyStimulus(1);
      MASK = 4'b0100; MODE = 1'b0; START = 1'b1;
      applyStimulus(1);                         // E
      START = 1'b0;
      checkOutput("post S", s_w[0], 2);
      applyStimulus(3);                         // E+3
      checkOutput("post SAMPLE early", sample_w[0], 0);
      applyStimulus(1);                         // E+4
      checkOutput("post SAMPLE", sample_w[0], 1);
      applyStimulus(1);                         // E+5
      checkOutput("post DONE", done_w[0], 1);
      applyStimulus(3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
